alu_control_mc: RTL and testbench
=================================

ALU_CONTROL_MC -- requirements
Module: alu_control_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width; legal values 8, 16, 32, 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port valid_in  input  1  the EX-stage instruction is valid this cycle.
REQ-005 SHALL have port alu_op  input  2  main-control ALU class.
REQ-006 SHALL have port funct  input  6  R-type function field.
REQ-007 SHALL have port rs_val  input  WIDTH  operand A (multiplicand/dividend).
REQ-008 SHALL have port rt_val  input  WIDTH  operand B (multiplier/divisor).
REQ-009 SHALL have port select  output  4  ALU select code, combinational.
REQ-010 SHALL have port stall  output  1  freeze IF/ID/EX while a multi-cycle op runs.
REQ-011 SHALL have port done  output  1  one-cycle pulse: hi/lo just updated.
REQ-012 SHALL have ports hi, lo  output  WIDTH each  registered HI/LO results.

Function
REQ-013 select SHALL decode: alu_op 00->0010; 01->0110; 11->0000; 10 by funct: 100000/100001->0010, 100010/100011->0110, 100100->0000, 100101->0001, 100110->0011, 100111->1100, 101010->0111, 101011->1000, else 1111.
REQ-014 select SHALL be 0000 for alu_op=10 with MULTU 011001 / DIVU 011011 (ALU result unused).
REQ-015 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-016 start = state IDLE & valid_in & alu_op=10 & funct in {011001, 011011}; start SHALL capture rs_val/rt_val and enter MUL or DIV with iteration counter 0.
REQ-017 MUL SHALL do one shift-add iteration per cycle, DIV one restoring-division iteration per cycle; after exactly WIDTH iterations go to DONE.
REQ-018 On entry to DONE: MULTU -> {hi,lo} = full 2*WIDTH product; DIVU -> lo = quotient, hi = remainder.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-020 stall SHALL be combinational: 1 when start is true in IDLE, and in MUL and DIV; 0 in DONE and otherwise.
REQ-021 Latency: start sampled at edge E0 -> hi/lo valid and done=1 after edge E0+WIDTH+1... precisely the cycle following edge E0+WIDTH; stall high for WIDTH+1 cycles (start cycle plus WIDTH).
REQ-022 valid_in, alu_op, funct, operand changes SHALL be ignored outside IDLE; no queueing of a second start.
REQ-023 Divide by zero SHALL run the full WIDTH cycles and yield lo = all ones, hi = rs_val.
REQ-024 hi/lo SHALL hold their values except on DONE entry.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, hi=0, lo=0, done=0, internal operand registers 0, at any time including mid-MUL/DIV; stall then follows REQ-020 from IDLE.
REQ-026 An aborted operation SHALL leave no partial hi/lo update after reset release.

Configuration
REQ-027 Macro MULDIV_SIGNED_EN defined: MULT 011000 and DIV 011010 SHALL start like REQ-016 (select 0000), operating on magnitudes then sign-fixing: product/quotient negative iff operand signs differ, remainder takes dividend sign; divide by zero still per REQ-023.
REQ-028 Macro undefined: 011000/011010 SHALL decode select=1111 and SHALL NOT start or stall.

Verification (WIDTH=32)
REQ-029 MULTU rs=FFFFFFFF rt=00000002 -> stall 33 cycles, done pulse once, hi=00000001, lo=FFFFFFFE.
REQ-030 DIVU rs=100 rt=7 -> lo=14, hi=2; DIVU rs=5 rt=0 -> lo=FFFFFFFF, hi=5, same latency.
REQ-031 Decode sweep of every alu_op/funct of REQ-013/014 with valid_in=0 -> exact select codes, stall never asserts.
REQ-032 Start MULTU, assert rst_n=0 at iteration 10 -> same-cycle hi=lo=0, done=0, state IDLE; new DIVU after release completes correctly.
REQ-033 With MULDIV_SIGNED_EN: MULT -3*5 -> hi=FFFFFFFF lo=FFFFFFF1; DIV -7/2 -> lo=FFFFFFFD hi=FFFFFFFF; without macro same ops -> select=1111, no stall.

Source files
------------

// File: rtl/alu_control_mc.sv
// alu_control_mc: EX-stage ALU select decoder with a multi-cycle HI/LO unit.
// Unsigned multiply (shift-add) and divide (restoring) take WIDTH cycles and
// stall the front of the pipeline while they run.
// Optional feature: define MULDIV_SIGNED_EN to add signed MULT/DIV, which run
// on operand magnitudes and fix up the signs when the result is written.
module alu_control_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       select,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t r_state, w_stateNext;

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic               r_negMain;
    logic               r_negRem;
    logic               r_divZero;

    logic               w_rtype, w_isMultu, w_isDivu, w_isMult, w_isDiv;
    logic               w_mulStart, w_divStart, w_start, w_signedOp;
    logic               w_rsNeg, w_rtNeg;
    logic [WIDTH-1:0]   w_rsMag, w_rtMag;
    logic [2*WIDTH-1:0] w_prodNext, w_prodFinal;
    logic [WIDTH:0]     w_remShift, w_diff;
    logic [WIDTH-1:0]   w_remNext, w_quotNext, w_remFinal, w_quotFinal;

    assign w_rtype   = (alu_op == 2'b10);
    assign w_isMultu = (funct == 6'b011001);
    assign w_isDivu  = (funct == 6'b011011);
`ifdef MULDIV_SIGNED_EN
    assign w_isMult  = (funct == 6'b011000);
    assign w_isDiv   = (funct == 6'b011010);
`else
    assign w_isMult  = 1'b0;
    assign w_isDiv   = 1'b0;
`endif

    assign w_mulStart = w_rtype & (w_isMultu | w_isMult);
    assign w_divStart = w_rtype & (w_isDivu | w_isDiv);
    assign w_start    = (r_state == IDLE) & valid_in & (w_mulStart | w_divStart);
    assign w_signedOp = w_isMult | w_isDiv;

    // Signed ops are run on magnitudes; the unsigned ops pass operands through.
    assign w_rsNeg = w_signedOp & rs_val[WIDTH-1];
    assign w_rtNeg = w_signedOp & rt_val[WIDTH-1];
    assign w_rsMag = w_rsNeg ? (~rs_val + 1'b1) : rs_val;
    assign w_rtMag = w_rtNeg ? (~rt_val + 1'b1) : rt_val;

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    assign w_prodNext = r_prod + (r_mplier[0] ? r_mcand : '0);

    // One restoring-division step: shift in the next dividend bit, try to subtract.
    assign w_remShift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff     = w_remShift - {1'b0, r_divisor};
    assign w_remNext  = w_diff[WIDTH] ? w_remShift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quotNext = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};

    // Sign fix-up; a zero divisor keeps the all-ones quotient, and the remainder
    // then equals the dividend once its sign is restored.
    assign w_prodFinal = r_negMain ? (~w_prodNext + 1'b1) : w_prodNext;
    assign w_quotFinal = r_divZero ? {WIDTH{1'b1}}
                       : (r_negMain ? (~w_quotNext + 1'b1) : w_quotNext);
    assign w_remFinal  = r_negRem ? (~w_remNext + 1'b1) : w_remNext;

    assign stall = w_start | (r_state == MUL) | (r_state == DIV);
    assign done  = (r_state == DONE);

    // ALU select decode from the main-control class and the R-type function field.
    always_comb begin
        select = 4'b1111;
        case (alu_op)
            2'b00: select = 4'b0010;
            2'b01: select = 4'b0110;
            2'b11: select = 4'b0000;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: select = 4'b0010;
                    6'b100010, 6'b100011: select = 4'b0110;
                    6'b100100:            select = 4'b0000;
                    6'b100101:            select = 4'b0001;
                    6'b100110:            select = 4'b0011;
                    6'b100111:            select = 4'b1100;
                    6'b101010:            select = 4'b0111;
                    6'b101011:            select = 4'b1000;
                    6'b011001, 6'b011011: select = 4'b0000;
                    default: begin
                        if (w_signedOp) select = 4'b0000;
                    end
                endcase
            end
        endcase
    end

    // Next-state logic: start launches MUL/DIV, WIDTH iterations lead to a one-cycle DONE.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) w_stateNext = w_mulStart ? MUL : DIV;
            end
            MUL, DIV: begin
                if (r_cnt == LAST) w_stateNext = DONE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_stateNext;
    end

    // Datapath: capture operands on start, iterate, and write HI/LO only on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_negMain <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_cnt     <= '0;
                        r_mcand   <= {{WIDTH{1'b0}}, w_rsMag};
                        r_mplier  <= w_rtMag;
                        r_prod    <= '0;
                        r_divisor <= w_rtMag;
                        r_rem     <= '0;
                        r_quot    <= w_rsMag;
                        r_negMain <= w_rsNeg ^ w_rtNeg;
                        r_negRem  <= w_rsNeg;
                        r_divZero <= (rt_val == '0);
                    end
                end
                MUL: begin
                    r_prod   <= w_prodNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST) {hi, lo} <= w_prodFinal;
                end
                DIV: begin
                    r_rem  <= w_remNext;
                    r_quot <= w_quotNext;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        hi <= w_remFinal;
                        lo <= w_quotFinal;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: directed vectors with hand-computed results for the
// select decoder, MULTU/DIVU latency and results, reset abort, and the
// MULDIV_SIGNED_EN signed operations (or their absence).
module tb_alu_control_mc;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             valid_in;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [3:0]       select;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checkCount = 0;
    int passCount  = 0;

    alu_control_mc #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .alu_op   (alu_op),
        .funct    (funct),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .select   (select),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] fn,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        valid_in = v;
        alu_op   = op;
        funct    = fn;
        rs_val   = a;
        rt_val   = b;
    endtask

    // Launch one multi-cycle op, scramble inputs while busy, and check latency and results.
    task automatic runOp(input string tag, input logic [5:0] fn,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] prevHi, input logic [WIDTH-1:0] prevLo,
                         input logic [WIDTH-1:0] expHi, input logic [WIDTH-1:0] expLo);
        int stallCount = 0;
        int doneCount  = 0;
        int doneIdx    = -1;
        @(negedge clk);
        applyStimulus(1'b1, 2'b10, fn, a, b);
        #1;
        for (int i = 0; i < WIDTH + 6; i++) begin
            if (stall) stallCount++;
            if (done) begin
                doneCount++;
                doneIdx = i;
            end
            if (i == WIDTH) begin
                checkOutput({tag, " hold hi"}, 64'(hi), 64'(prevHi));
                checkOutput({tag, " hold lo"}, 64'(lo), 64'(prevLo));
            end
            @(posedge clk);
            #1;
            if (i == 0) applyStimulus(1'b1, 2'b10, 6'b100000, ~a, ~b);
            @(negedge clk);
        end
        applyStimulus(1'b0, 2'b00, 6'b000000, '0, '0);
        checkOutput({tag, " stall cycles"}, 64'(stallCount), 64'(WIDTH + 1));
        checkOutput({tag, " done pulses"}, 64'(doneCount), 64'd1);
        checkOutput({tag, " done cycle"}, 64'(doneIdx), 64'(WIDTH + 1));
        checkOutput({tag, " hi"}, 64'(hi), 64'(expHi));
        checkOutput({tag, " lo"}, 64'(lo), 64'(expLo));
    endtask

    logic [1:0] sweepOp  [20];
    logic [5:0] sweepFn  [20];
    logic [3:0] sweepSel [20];

    // Main directed sequence.
    initial begin
        sweepOp[0]  = 2'b00; sweepFn[0]  = 6'b000000; sweepSel[0]  = 4'b0010;
        sweepOp[1]  = 2'b01; sweepFn[1]  = 6'b100101; sweepSel[1]  = 4'b0110;
        sweepOp[2]  = 2'b11; sweepFn[2]  = 6'b100111; sweepSel[2]  = 4'b0000;
        sweepOp[3]  = 2'b10; sweepFn[3]  = 6'b100000; sweepSel[3]  = 4'b0010;
        sweepOp[4]  = 2'b10; sweepFn[4]  = 6'b100001; sweepSel[4]  = 4'b0010;
        sweepOp[5]  = 2'b10; sweepFn[5]  = 6'b100010; sweepSel[5]  = 4'b0110;
        sweepOp[6]  = 2'b10; sweepFn[6]  = 6'b100011; sweepSel[6]  = 4'b0110;
        sweepOp[7]  = 2'b10; sweepFn[7]  = 6'b100100; sweepSel[7]  = 4'b0000;
        sweepOp[8]  = 2'b10; sweepFn[8]  = 6'b100101; sweepSel[8]  = 4'b0001;
        sweepOp[9]  = 2'b10; sweepFn[9]  = 6'b100110; sweepSel[9]  = 4'b0011;
        sweepOp[10] = 2'b10; sweepFn[10] = 6'b100111; sweepSel[10] = 4'b1100;
        sweepOp[11] = 2'b10; sweepFn[11] = 6'b101010; sweepSel[11] = 4'b0111;
        sweepOp[12] = 2'b10; sweepFn[12] = 6'b101011; sweepSel[12] = 4'b1000;
        sweepOp[13] = 2'b10; sweepFn[13] = 6'b011001; sweepSel[13] = 4'b0000;
        sweepOp[14] = 2'b10; sweepFn[14] = 6'b011011; sweepSel[14] = 4'b0000;
        sweepOp[15] = 2'b10; sweepFn[15] = 6'b000000; sweepSel[15] = 4'b1111;
        sweepOp[16] = 2'b10; sweepFn[16] = 6'b111111; sweepSel[16] = 4'b1111;
`ifdef MULDIV_SIGNED_EN
        sweepOp[17] = 2'b10; sweepFn[17] = 6'b011000; sweepSel[17] = 4'b0000;
        sweepOp[18] = 2'b10; sweepFn[18] = 6'b011010; sweepSel[18] = 4'b0000;
`else
        sweepOp[17] = 2'b10; sweepFn[17] = 6'b011000; sweepSel[17] = 4'b1111;
        sweepOp[18] = 2'b10; sweepFn[18] = 6'b011010; sweepSel[18] = 4'b1111;
`endif
        sweepOp[19] = 2'b00; sweepFn[19] = 6'b011001; sweepSel[19] = 4'b0010;

        rst_n = 1'b0;
        applyStimulus(1'b0, 2'b00, 6'b000000, '0, '0);
        #1;
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset stall", 64'(stall), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, sweepOp[i], sweepFn[i], 32'h1234, 32'h5678);
            #1;
            checkOutput($sformatf("decode %0d select", i), 64'(select), 64'(sweepSel[i]));
            checkOutput($sformatf("decode %0d stall", i), 64'(stall), 64'd0);
        end

        runOp("multu ffffffff*2", 6'b011001, 32'hFFFFFFFF, 32'h00000002,
              32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE);
        runOp("multu ffff*ffff", 6'b011001, 32'h0000FFFF, 32'h0000FFFF,
              32'h00000001, 32'hFFFFFFFE, 32'h00000000, 32'hFFFE0001);
        runOp("multu 10000*10000", 6'b011001, 32'h00010000, 32'h00010000,
              32'h00000000, 32'hFFFE0001, 32'h00000001, 32'h00000000);
        runOp("divu 100/7", 6'b011011, 32'd100, 32'd7,
              32'h00000001, 32'h00000000, 32'd2, 32'd14);
        runOp("divu 5/0", 6'b011011, 32'd5, 32'd0,
              32'd2, 32'd14, 32'd5, 32'hFFFFFFFF);

        @(negedge clk);
        applyStimulus(1'b1, 2'b10, 6'b011001, 32'hFFFFFFFF, 32'h00000002);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'b00, 6'b000000, '0, '0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("pre-abort stall", 64'(stall), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort hi", 64'(hi), 64'd0);
        checkOutput("abort lo", 64'(lo), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("divu after abort", 6'b011011, 32'd100, 32'd7,
              32'd0, 32'd0, 32'd2, 32'd14);

`ifdef MULDIV_SIGNED_EN
        runOp("mult -3*5", 6'b011000, 32'hFFFFFFFD, 32'd5,
              32'd2, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFF1);
        runOp("div -7/2", 6'b011010, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFFFD);
`else
        begin
            int doneSeen = 0;
            int stallSeen = 0;
            @(negedge clk);
            applyStimulus(1'b1, 2'b10, 6'b011000, 32'hFFFFFFFD, 32'd5);
            #1;
            checkOutput("mult off select", 64'(select), 64'hF);
            for (int i = 0; i < 4; i++) begin
                if (stall) stallSeen++;
                if (done) doneSeen++;
                @(negedge clk);
            end
            applyStimulus(1'b1, 2'b10, 6'b011010, 32'hFFFFFFF9, 32'd2);
            #1;
            checkOutput("div off select", 64'(select), 64'hF);
            for (int i = 0; i < 4; i++) begin
                if (stall) stallSeen++;
                if (done) doneSeen++;
                @(negedge clk);
            end
            applyStimulus(1'b0, 2'b00, 6'b000000, '0, '0);
            checkOutput("signed off stall", 64'(stallSeen), 64'd0);
            checkOutput("signed off done", 64'(doneSeen), 64'd0);
            checkOutput("signed off hi", 64'(hi), 64'd2);
            checkOutput("signed off lo", 64'(lo), 64'd14);
        end
`endif

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
